// File: rtl/ycr_ahb_resp_pkg.sv
// Shared encodings, FSM type and byte-lane helper for the AHB-Lite SRAM responder.
package ycr_ahb_resp_pkg;

  localparam int YCR_AHB_WIDTH = 32;

  localparam logic [1:0] YCR_AHB_HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] YCR_AHB_HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] YCR_AHB_HSIZE_8BIT  = 3'b000;
  localparam logic [2:0] YCR_AHB_HSIZE_16BIT = 3'b001;
  localparam logic [2:0] YCR_AHB_HSIZE_32BIT = 3'b010;

  localparam logic YCR_AHB_HRESP_OKAY  = 1'b0;
  localparam logic YCR_AHB_HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    YCR_AHB_RESP_FSM_IDLE,
    YCR_AHB_RESP_FSM_WAIT,
    YCR_AHB_RESP_FSM_ERR1,
    YCR_AHB_RESP_FSM_ERR2
  } type_ycr_ahb_resp_fsm_e;

  function automatic logic [3:0] ycr_ahb_be(input logic [2:0] hsize, input logic [1:0] addr);
    logic [3:0] be;
    be = 4'b0000;
    case (hsize)
      YCR_AHB_HSIZE_8BIT:  be = 4'b0001 << addr;
      YCR_AHB_HSIZE_16BIT: be = addr[1] ? 4'b1100 : 4'b0011;
      YCR_AHB_HSIZE_32BIT: be = 4'b1111;
      default:             be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ycr_ahb_resp_mem.sv
// Word-addressed register array with byte-enable writes and a registered read port.
// A read issued in the same cycle as a write to the same word sees the merged new bytes.
module ycr_ahb_resp_mem #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [DW/8-1:0] wbe_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic            re_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [DW-1:0]   rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;

  // array contents are intentionally left unreset
  always_ff @(posedge clk) begin
    for (int b = 0; b < DW/8; b++) begin
      if (we_i && wbe_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  always_comb begin
    rdata_d = mem_q[raddr_i];
    if (we_i && (waddr_i == raddr_i)) begin
      for (int b = 0; b < DW/8; b++) begin
        if (wbe_i[b]) rdata_d[8*b +: 8] = wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ycr_ahb_sram_resp.sv
// AHB-Lite responder backed by an internal SRAM array, with fixed wait states and ERROR replies.
// Define YCR_AHB_RESP_RANDSTALL_EN to add LFSR-driven extra wait cycles to OKAY transfers.
module ycr_ahb_sram_resp
  import ycr_ahb_resp_pkg::*;
#(
  parameter int          MEM_AW      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hsel,
  input  logic                     hready_in,
  input  logic [1:0]               htrans,
  input  logic [31:0]              haddr,
  input  logic                     hwrite,
  input  logic [2:0]               hsize,
  input  logic [YCR_AHB_WIDTH-1:0] hwdata,
  output logic                     hready,
  output logic [YCR_AHB_WIDTH-1:0] hrdata,
  output logic                     hresp
);

  localparam int CNT_W = 5;

  type_ycr_ahb_resp_fsm_e state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dp_valid_q, dp_valid_d;
  logic              dp_write_q, dp_write_d;
  logic [MEM_AW-1:0] dp_widx_q, dp_widx_d;
  logic [3:0]        dp_be_q, dp_be_d;

  logic                     in_err;
  logic                     accept;
  logic                     addr_ok;
  logic                     size_err;
  logic                     align_err;
  logic                     acc_err;
  logic                     acc_ok;
  logic                     complete;
  logic                     mem_we;
  logic [CNT_W-1:0]         stall_total;
  logic [YCR_AHB_WIDTH-1:0] mem_rdata;

  assign in_err = (state_q == YCR_AHB_RESP_FSM_ERR1) || (state_q == YCR_AHB_RESP_FSM_ERR2);
  assign hready = (state_q == YCR_AHB_RESP_FSM_IDLE) || (state_q == YCR_AHB_RESP_FSM_ERR2);
  assign hresp  = in_err ? YCR_AHB_HRESP_ERROR : YCR_AHB_HRESP_OKAY;
  assign hrdata = in_err ? '0 : mem_rdata;

  assign accept    = hsel & hready_in & hready &
                     ((htrans == YCR_AHB_HTRANS_NONSEQ) | (htrans == YCR_AHB_HTRANS_SEQ));
  // BASE_ADDR is aligned to the array size, so range check is an upper-bit compare
  assign addr_ok   = (haddr[31:MEM_AW+2] == BASE_ADDR[31:MEM_AW+2]);
  assign size_err  = (hsize > YCR_AHB_HSIZE_32BIT);
  assign align_err = ((hsize == YCR_AHB_HSIZE_16BIT) & haddr[0]) |
                     ((hsize == YCR_AHB_HSIZE_32BIT) & (haddr[1:0] != 2'b00));
  assign acc_err   = ~addr_ok | size_err | align_err;
  assign acc_ok    = accept & ~acc_err;
  assign complete  = dp_valid_q & (state_q == YCR_AHB_RESP_FSM_IDLE);
  assign mem_we    = complete & dp_write_q & ~rst;

`ifdef YCR_AHB_RESP_RANDSTALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst)         lfsr_q <= 16'hACE1;
    else if (acc_ok) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign stall_total = CNT_W'(WAIT_STATES) + CNT_W'(lfsr_q[1:0]);
`else
  assign stall_total = CNT_W'(WAIT_STATES);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_widx_d  = dp_widx_q;
    dp_be_d    = dp_be_q;
    if (complete) dp_valid_d = 1'b0;
    case (state_q)
      YCR_AHB_RESP_FSM_IDLE,
      YCR_AHB_RESP_FSM_ERR2: begin
        state_d = YCR_AHB_RESP_FSM_IDLE;
        if (accept) begin
          if (acc_err) begin
            state_d = YCR_AHB_RESP_FSM_ERR1;
          end else begin
            dp_valid_d = 1'b1;
            dp_write_d = hwrite;
            dp_widx_d  = haddr[MEM_AW+1:2];
            dp_be_d    = ycr_ahb_be(hsize, haddr[1:0]);
            if (stall_total != '0) begin
              state_d = YCR_AHB_RESP_FSM_WAIT;
              cnt_d   = stall_total - CNT_W'(1);
            end
          end
        end
      end
      YCR_AHB_RESP_FSM_WAIT: begin
        if (cnt_q == '0) state_d = YCR_AHB_RESP_FSM_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      YCR_AHB_RESP_FSM_ERR1: state_d = YCR_AHB_RESP_FSM_ERR2;
      default:               state_d = YCR_AHB_RESP_FSM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= YCR_AHB_RESP_FSM_IDLE;
      cnt_q      <= '0;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_widx_q  <= '0;
      dp_be_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_widx_q  <= dp_widx_d;
      dp_be_q    <= dp_be_d;
    end
  end

  // read is launched at address accept so zero-wait data lands in the next cycle
  ycr_ahb_resp_mem #(
    .AW (MEM_AW),
    .DW (YCR_AHB_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we),
    .waddr_i (dp_widx_q),
    .wbe_i   (dp_be_q),
    .wdata_i (hwdata),
    .re_i    (acc_ok & ~hwrite),
    .raddr_i (haddr[MEM_AW+1:2]),
    .rdata_o (mem_rdata)
  );

endmodule
